// File: rtl/sz_model2_decode.sv
// SZ 2nd-order Lorenzo inverse: rebuilds samples from quant codes, 1/cycle.
// Optional SZ_DECODE_SAT_EN: saturate non-escape results, add sat_flag.
module sz_model2_decode #(
   parameter int DATA_W   = 32,
   parameter int CODE_W   = 8,
   parameter int EB_SHIFT = 1,
   parameter int LEN_W    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [LEN_W-1:0]         blk_len,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CODE_W-1:0]        in_code,
   input  logic signed [DATA_W-1:0] in_literal,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_last,
   output logic                     busy,
   output logic                     done,
   output logic [LEN_W-1:0]         esc_cnt
`ifdef SZ_DECODE_SAT_EN
   ,
   output logic                     sat_flag
`endif
);

   localparam int PW = DATA_W + 3;
   localparam int SW = DATA_W + 4;
   localparam logic [CODE_W:0] RAD = {2'b01, {(CODE_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] MAXV = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] MINV = ~MAXV;

   typedef enum logic [2:0] {IDLE, S0, S1, S2, RUN} state_t;

   state_t                    state_q;
   logic [LEN_W-1:0]          len_q;
   logic [LEN_W-1:0]          cnt_q;
   logic [LEN_W-1:0]          esc_q;
   logic signed [DATA_W-1:0]  r1_q;
   logic signed [DATA_W-1:0]  r2_q;
   logic signed [DATA_W-1:0]  r3_q;
   logic                      ov_q;
   logic [DATA_W-1:0]         od_q;
   logic                      ol_q;
   logic                      sat_q;

   logic signed [PW-1:0]      e1, e2, e3, pred;
   logic [CODE_W:0]           qd_u;
   logic signed [SW-1:0]      dq, delta, sp, sum;
   logic signed [DATA_W-1:0]  recon_d;
   logic                      sat_d;
   logic                      accept, esc, last_acc;

   assign busy      = (state_q != IDLE);
   assign in_ready  = busy && (!ov_q || out_ready);
   assign accept    = in_ready && in_valid;
   assign esc       = (in_code == '0);
   assign last_acc  = (cnt_q == len_q - 1'b1);
   assign out_valid = ov_q;
   assign out_data  = od_q;
   assign out_last  = ol_q;
   assign done      = ov_q && out_ready && ol_q;
   assign esc_cnt   = esc_q;
`ifdef SZ_DECODE_SAT_EN
   assign sat_flag  = sat_q;
`endif

   assign e1 = r1_q;
   assign e2 = r2_q;
   assign e3 = r3_q;

   always_comb begin
      pred = '0;
      unique case (state_q)
         S1:      pred = e1;
         S2:      pred = (e1 <<< 1) - e2;
         RUN:     pred = (e1 <<< 1) + e1 - (e2 <<< 1) - e2 + e3;
         default: pred = '0;
      endcase
      qd_u  = {1'b0, in_code} - RAD;
      dq    = $signed(qd_u);
      delta = dq <<< EB_SHIFT;
      sp    = pred;
      sum   = sp + delta;
      sat_d = 1'b0;
`ifdef SZ_DECODE_SAT_EN
      if (sum > $signed({4'b0000, MAXV})) begin
         recon_d = MAXV;
         sat_d   = 1'b1;
      end else if (sum < $signed({4'b1111, MINV})) begin
         recon_d = MINV;
         sat_d   = 1'b1;
      end else begin
         recon_d = DATA_W'(sum);
      end
`else
      recon_d = DATA_W'(sum);
`endif
      if (esc) begin
         recon_d = in_literal;
         sat_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         esc_q   <= '0;
         r1_q    <= '0;
         r2_q    <= '0;
         r3_q    <= '0;
         ov_q    <= 1'b0;
         od_q    <= '0;
         ol_q    <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         if (ov_q && out_ready) ov_q <= 1'b0;
         if (accept) begin
            ov_q  <= 1'b1;
            od_q  <= recon_d;
            ol_q  <= last_acc;
            r3_q  <= r2_q;
            r2_q  <= r1_q;
            r1_q  <= recon_d;
            cnt_q <= cnt_q + 1'b1;
            if (esc && esc_q != '1) esc_q <= esc_q + 1'b1;
            if (sat_d) sat_q <= 1'b1;
            if (last_acc) state_q <= IDLE;
            else begin
               unique case (state_q)
                  S0:      state_q <= S1;
                  S1:      state_q <= S2;
                  default: state_q <= RUN;
               endcase
            end
         end
         // start is only honoured from IDLE, so it never races an accept
         if (state_q == IDLE && start) begin
            state_q <= S0;
            len_q   <= (blk_len == '0) ? LEN_W'(1) : blk_len;
            cnt_q   <= '0;
            esc_q   <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            r3_q    <= '0;
            sat_q   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sz_model2_decode.sv
// Bench for sz_model2_decode (DATA_W=16): sample-list model + directed blocks.
// Build with SZ_DECODE_SAT_EN to exercise saturation.
module tb_sz_model2_decode;

   localparam int DW = 16;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [LW-1:0] blk_len = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [7:0]    in_code = '0;
   logic [DW-1:0] in_literal = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          busy;
   logic          done;
   logic [LW-1:0] esc_cnt;
`ifdef SZ_DECODE_SAT_EN
   logic          sat_flag;
`endif

   always #5 clk = ~clk;

   sz_model2_decode #(.DATA_W(DW), .CODE_W(8), .EB_SHIFT(1), .LEN_W(LW)) dut (
      .clk(clk), .rst(rst), .start(start), .blk_len(blk_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
      .in_literal(in_literal), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
      .esc_cnt(esc_cnt)
`ifdef SZ_DECODE_SAT_EN
      , .sat_flag(sat_flag)
`endif
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string n, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
      end
   endtask

   // Model: block as a list of reconstructed samples, prediction by index.
   bit     m_busy, m_ov, m_ol, m_sat;
   longint m_od;
   int     m_idx, m_len, m_esc;
   longint blk[$];

   task automatic model_step();
      bit b0, acc;
      int k;
      longint p, v;
      logic signed [DW-1:0] t;
      if (rst) begin
         m_busy = 0; m_ov = 0; m_ol = 0; m_od = 0; m_sat = 0;
         m_idx = 0; m_esc = 0; blk.delete();
         return;
      end
      b0  = m_busy;
      acc = m_busy && (!m_ov || out_ready) && in_valid;
      if (m_ov && out_ready) m_ov = 0;
      if (acc) begin
         k = m_idx;
         if (k == 0) p = 0;
         else if (k == 1) p = blk[k-1];
         else if (k == 2) p = 2*blk[k-1] - blk[k-2];
         else p = 3*blk[k-1] - 3*blk[k-2] + blk[k-3];
         if (in_code == 0) begin
            t = in_literal;
            v = t;
            if (m_esc < 65535) m_esc++;
         end else begin
            v = p + (longint'(in_code) - 128) * 2;
`ifdef SZ_DECODE_SAT_EN
            if (v > 32767) begin v = 32767; m_sat = 1; end
            else if (v < -32768) begin v = -32768; m_sat = 1; end
`else
            t = v[DW-1:0];
            v = t;
`endif
         end
         blk.push_back(v);
         m_ov = 1; m_od = v;
         m_ol = (k == m_len - 1);
         m_idx++;
         if (m_ol) m_busy = 0;
      end
      if (!b0 && start) begin
         m_busy = 1;
         m_len  = (blk_len == 0) ? 1 : int'(blk_len);
         m_idx  = 0; m_esc = 0; m_sat = 0;
         blk.delete();
      end
   endtask

   longint got[$];
   int     done_cnt = 0;

   initial forever begin
      @(posedge clk);
      model_step();
      if (out_valid && out_ready) got.push_back(longint'($signed(out_data)));
      if (done) done_cnt++;
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("out_valid", out_valid, m_ov);
         chk("busy", busy, m_busy);
         chk("in_ready", in_ready, m_busy && (!m_ov || out_ready));
         chk("done", done, m_ov && out_ready && m_ol);
         chk("esc_cnt", esc_cnt, m_esc);
         if (m_ov) begin
            chk("out_data", longint'($signed(out_data)), m_od);
            chk("out_last", out_last, m_ol);
         end
`ifdef SZ_DECODE_SAT_EN
         chk("sat_flag", sat_flag, m_sat);
`endif
      end
   end

   logic [7:0]    cq[$];
   logic [DW-1:0] lq[$];
   longint        eq[$];

   task automatic send(input logic [7:0] c, input logic [DW-1:0] l);
      bit ok = 0;
      in_valid = 1; in_code = c; in_literal = l;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 0;
      if (!ok) chk("send_timeout", 0, 1);
   endtask

   task automatic pulse_start(input int len);
      start = 1; blk_len = LW'(len);
      @(posedge clk);
      #1;
      start = 0;
   endtask

   task automatic drain();
      bit ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = !busy && !out_valid;
      end
      if (!ok) chk("drain_timeout", 0, 1);
   endtask

   task automatic run_blk(input int len);
      got.delete(); done_cnt = 0;
      pulse_start(len);
      for (int i = 0; i < cq.size(); i++) send(cq[i], lq[i]);
      drain();
   endtask

   task automatic pin(input string n);
      chk({n, "_count"}, got.size(), eq.size());
      for (int i = 0; i < eq.size(); i++)
         if (i < got.size()) chk({n, "_val"}, got[i], eq[i]);
   endtask

   task automatic stall3();
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (got.size() >= 1) break;
      end
      out_ready = 0;
      repeat (3) begin
         @(negedge clk);
         chk("hold_data", longint'($signed(out_data)), 2);
         chk("hold_ir", in_ready, 0);
      end
      @(posedge clk);
      #1;
      out_ready = 1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1;
      @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data", out_data, 0);
      chk("rst_esc", esc_cnt, 0);
      rst = 0;
      @(posedge clk);
      #1;

      cq = '{8'd0, 8'd129, 8'd128, 8'd128, 8'd128};
      lq = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
      eq = '{0, 2, 4, 6, 8};
      run_blk(5);
      pin("ramp");
      chk("ramp_done", done_cnt, 1);
      chk("ramp_esc", esc_cnt, 1);

      got.delete(); done_cnt = 0;
      fork
         begin
            pulse_start(5);
            for (int i = 0; i < cq.size(); i++) send(cq[i], lq[i]);
            drain();
         end
         stall3();
      join
      pin("bp");
      chk("bp_done", done_cnt, 1);

      cq = '{8'd0}; lq = '{16'hFFF9}; eq = '{-7};
      run_blk(1);
      pin("len1");
      chk("len1_done", done_cnt, 1);

      cq = '{8'd0, 8'd127}; lq = '{16'd5, 16'd0}; eq = '{5, 3};
      run_blk(2);
      pin("len2");
      chk("len2_idle", busy, 0);

      cq = '{8'd0, 8'd129, 8'd128, 8'd129};
      lq = '{16'd32762, 16'd0, 16'd0, 16'd0};
`ifdef SZ_DECODE_SAT_EN
      eq = '{32762, 32764, 32766, 32767};
`else
      eq = '{32762, 32764, 32766, -32766};
`endif
      run_blk(4);
      pin("wrap");
`ifdef SZ_DECODE_SAT_EN
      chk("sat_flag_set", sat_flag, 1);
`endif

      got.delete(); done_cnt = 0;
      pulse_start(5);
      send(8'd0, 16'd20);
      send(8'd130, 16'd0);
      send(8'd128, 16'd0);
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      @(negedge clk);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_esc", esc_cnt, 0);
      cq = '{8'd0, 8'd128}; lq = '{16'd9, 16'd0}; eq = '{9, 9};
      run_blk(2);
      pin("after_rst");

      got.delete(); done_cnt = 0;
      pulse_start(3);
      send(8'd0, 16'd1);
      pulse_start(1);
      send(8'd128, 16'd0);
      send(8'd128, 16'd0);
      drain();
      eq = '{1, 1, 1};
      pin("start_busy");
      chk("start_busy_done", done_cnt, 1);

      cq = '{8'd0}; lq = '{16'd4}; eq = '{4};
      run_blk(0);
      pin("len0");
      chk("len0_done", done_cnt, 1);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
